// File: rtl/freq_seq_pkg.sv
// Shared types and default widths for the frequency step sequencer.
//   state_t : sequencer FSM states
//   entry_t : one table entry {div, dwell} at default widths
package freq_seq_pkg;

  localparam int unsigned DEF_DIV_W   = 28;
  localparam int unsigned DEF_DWELL_W = 32;
  localparam int unsigned DEF_DEPTH   = 8;
  localparam int unsigned DEF_IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_DIV_W-1:0]   div;
    logic [DEF_DWELL_W-1:0] dwell;
  } entry_t;

endpackage

// File: rtl/freq_step_sequencer_if.sv
// Control/status bundle between the table programmer (master) and the
// sequencer (slave).
//   master drives: wr_en, wr_addr, wr_div, wr_dwell, num_steps, loop_en,
//                  start, stop, hold
//   slave drives : frequencySelect, div_enable, busy, step_idx,
//                  step_pulse, done
interface freq_step_sequencer_if
  import freq_seq_pkg::*;
#(
  parameter int unsigned DIV_W   = DEF_DIV_W,
  parameter int unsigned DWELL_W = DEF_DWELL_W,
  parameter int unsigned IDX_W   = DEF_IDX_W
);

  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [DIV_W-1:0]   wr_div;
  logic [DWELL_W-1:0] wr_dwell;
  logic [IDX_W:0]     num_steps;
  logic               loop_en;
  logic               start;
  logic               stop;
  logic               hold;

  logic [DIV_W-1:0]   frequencySelect;
  logic               div_enable;
  logic               busy;
  logic [IDX_W-1:0]   step_idx;
  logic               step_pulse;
  logic               done;

  modport master (
    output wr_en, wr_addr, wr_div, wr_dwell, num_steps, loop_en,
           start, stop, hold,
    input  frequencySelect, div_enable, busy, step_idx, step_pulse, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_div, wr_dwell, num_steps, loop_en,
           start, stop, hold,
    output frequencySelect, div_enable, busy, step_idx, step_pulse, done
  );

endinterface

// File: rtl/freq_seq_table.sv
// DEPTH-entry {div, dwell} register file, one synchronous write port and
// one combinational read port. Contents are not reset; writes are only
// suppressed while reset_n is low.
//   clock_in, reset_n        : clock / write gate
//   wr_en, wr_addr, wr_div,
//   wr_dwell                 : write port
//   rd_idx -> rd_div, rd_dwell : read port
module freq_seq_table
  import freq_seq_pkg::*;
#(
  parameter int unsigned DIV_W   = DEF_DIV_W,
  parameter int unsigned DWELL_W = DEF_DWELL_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned IDX_W   = DEF_IDX_W
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [DIV_W-1:0]   wr_div,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [DIV_W-1:0]   rd_div,
  output logic [DWELL_W-1:0] rd_dwell
);

  logic [DIV_W-1:0]   div_mem   [DEPTH];
  logic [DWELL_W-1:0] dwell_mem [DEPTH];

  // Write port; reset wins over a coincident write.
  always_ff @(posedge clock_in) begin
    if (reset_n && wr_en) begin
      div_mem[wr_addr]   <= wr_div;
      dwell_mem[wr_addr] <= wr_dwell;
    end
  end

  assign rd_div   = div_mem[rd_idx];
  assign rd_dwell = dwell_mem[rd_idx];

endmodule

// File: rtl/freq_step_sequencer.sv
// Plays a programmed table of (divisor, dwell) entries onto the clock
// divider's frequencySelect input, holding each divisor for max(dwell,1)
// non-held cycles, then finishing with a one-cycle done or looping.
//   clock_in : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : table write port, run controls and registered status
module freq_step_sequencer
  import freq_seq_pkg::*;
#(
  parameter int unsigned DIV_W   = DEF_DIV_W,
  parameter int unsigned DWELL_W = DEF_DWELL_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned IDX_W   = DEF_IDX_W
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  freq_step_sequencer_if.slave  bus
);

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [IDX_W:0]     steps_lat_q, steps_lat_d;
  logic [IDX_W-1:0]   step_idx_q, step_idx_d;
  logic [DIV_W-1:0]   freq_q, freq_d;
  logic               div_en_q, div_en_d;
  logic               busy_q, busy_d;
  logic               pulse_q, pulse_d;
  logic               done_q, done_d;

  logic               load_c;
  logic [IDX_W-1:0]   next_idx_c;
  logic [DIV_W-1:0]   rd_div;
  logic [DWELL_W-1:0] rd_dwell;

  freq_seq_table #(
    .DIV_W   (DIV_W),
    .DWELL_W (DWELL_W),
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W)
  ) u_table (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .wr_div   (bus.wr_div),
    .wr_dwell (bus.wr_dwell),
    .rd_idx   (next_idx_c),
    .rd_div   (rd_div),
    .rd_dwell (rd_dwell)
  );

  // State and output registers.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      steps_lat_q <= '0;
      step_idx_q  <= '0;
      freq_q      <= '0;
      div_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      pulse_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      steps_lat_q <= steps_lat_d;
      step_idx_q  <= step_idx_d;
      freq_q      <= freq_d;
      div_en_q    <= div_en_d;
      busy_q      <= busy_d;
      pulse_q     <= pulse_d;
      done_q      <= done_d;
    end
  end

  // Next-state, entry loading and output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    steps_lat_d = steps_lat_q;
    step_idx_d  = step_idx_q;
    freq_d      = freq_q;
    div_en_d    = div_en_q;
    busy_d      = busy_q;
    pulse_d     = 1'b0;
    done_d      = 1'b0;
    load_c      = 1'b0;
    next_idx_c  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && (bus.num_steps != '0)) begin
          load_c      = 1'b1;
          state_d     = RUN;
          steps_lat_d = (bus.num_steps > (IDX_W+1)'(DEPTH)) ?
                        (IDX_W+1)'(DEPTH) : bus.num_steps;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.hold) begin
          // Everything frozen; pulse already defaults low.
        end else if (cnt_q != '0) begin
          cnt_d = DWELL_W'(cnt_q - 1'b1);
        end else if ({1'b0, step_idx_q} < (IDX_W+1)'(steps_lat_q - 1'b1)) begin
          load_c     = 1'b1;
          next_idx_c = IDX_W'(step_idx_q + 1'b1);
        end else if (bus.loop_en) begin
          load_c = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Leaving RUN (to IDLE or DONE) clears all driven outputs.
    if (state_d != RUN) begin
      cnt_d      = '0;
      step_idx_d = '0;
      freq_d     = '0;
      div_en_d   = 1'b0;
      busy_d     = 1'b0;
    end

    // A load latches the entry now; later table writes don't disturb it.
    if (load_c) begin
      step_idx_d = next_idx_c;
      freq_d     = rd_div;
      div_en_d   = 1'b1;
      busy_d     = 1'b1;
      pulse_d    = 1'b1;
      cnt_d      = (rd_dwell == '0) ? '0 : DWELL_W'(rd_dwell - 1'b1);
    end
  end

  assign bus.frequencySelect = freq_q;
  assign bus.div_enable      = div_en_q;
  assign bus.busy            = busy_q;
  assign bus.step_idx        = step_idx_q;
  assign bus.step_pulse      = pulse_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_freq_step_sequencer.sv
// Directed self-checking bench for freq_step_sequencer.
module tb_freq_step_sequencer;
  import freq_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total;

  freq_step_sequencer_if bus ();

  freq_step_sequencer dut (
    .clock_in (clk),
    .reset_n  (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wr(input int addr, input entry_t e);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 3'(addr);
    bus.wr_div   = e.div;
    bus.wr_dwell = e.dwell;
    tick();
    bus.wr_en    = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_freq"},  32'(bus.frequencySelect), 32'd0);
    chk({tag, "_en"},    32'(bus.div_enable), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_idx"},   32'(bus.step_idx), 32'd0);
    chk({tag, "_pulse"}, 32'(bus.step_pulse), 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
  endtask

  // Expected sequence for table {2,3},{5,2},{7,1}.
  int exp_freq  [6] = '{2, 2, 2, 5, 5, 7};
  int exp_pulse [6] = '{1, 0, 0, 1, 0, 1};
  int exp_idx   [6] = '{0, 0, 0, 1, 1, 2};

  initial begin
    int   cycles;
    int   last_div;
    logic seen_done;
    pass_cnt = 0;
    total    = 0;
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_div = '0; bus.wr_dwell = '0;
    bus.num_steps = '0; bus.loop_en = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;

    // Reset
    tick(); tick();
    chk_idle("reset");
    rst_n = 1'b1;

    wr(0, '{div: 28'd2, dwell: 32'd3});
    wr(1, '{div: 28'd5, dwell: 32'd2});
    wr(2, '{div: 28'd7, dwell: 32'd1});
    chk_idle("post_write");

    // Single pass, no loop
    bus.num_steps = 4'd3; bus.loop_en = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      chk($sformatf("run_freq%0d", i),  32'(bus.frequencySelect), 32'(exp_freq[i]));
      chk($sformatf("run_pulse%0d", i), 32'(bus.step_pulse), 32'(exp_pulse[i]));
      chk($sformatf("run_idx%0d", i),   32'(bus.step_idx), 32'(exp_idx[i]));
      chk($sformatf("run_busy%0d", i),  32'(bus.busy), 32'd1);
      chk($sformatf("run_en%0d", i),    32'(bus.div_enable), 32'd1);
    end
    tick();
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_freq",  32'(bus.frequencySelect), 32'd0);
    chk("done_busy",  32'(bus.busy), 32'd0);
    chk("done_en",    32'(bus.div_enable), 32'd0);
    tick();
    chk_idle("after_done");

    // Looping: two full passes, never done
    bus.loop_en = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      chk($sformatf("loop_freq%0d", i),  32'(bus.frequencySelect), 32'(exp_freq[i % 6]));
      chk($sformatf("loop_pulse%0d", i), 32'(bus.step_pulse), 32'(exp_pulse[i % 6]));
      chk($sformatf("loop_busy%0d", i),  32'(bus.busy), 32'd1);
      chk($sformatf("loop_done%0d", i),  32'(bus.done), 32'd0);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0; bus.loop_en = 1'b0;
    chk_idle("loop_stop");

    // dwell=0 behaves as dwell=1
    wr(0, '{div: 28'd9, dwell: 32'd0});
    bus.num_steps = 4'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("d0_freq",  32'(bus.frequencySelect), 32'd9);
    chk("d0_pulse", 32'(bus.step_pulse), 32'd1);
    tick();
    chk("d0_done", 32'(bus.done), 32'd1);
    chk("d0_freq_off", 32'(bus.frequencySelect), 32'd0);
    tick();
    wr(0, '{div: 28'd2, dwell: 32'd3});

    // Hold 4 cycles in second cycle of entry 0: 7 cycles of div 2
    bus.num_steps = 4'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("hold_c1", 32'(bus.frequencySelect), 32'd2);
    tick();
    chk("hold_c2", 32'(bus.frequencySelect), 32'd2);
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold_freq%0d", i),  32'(bus.frequencySelect), 32'd2);
      chk($sformatf("hold_pulse%0d", i), 32'(bus.step_pulse), 32'd0);
      chk($sformatf("hold_busy%0d", i),  32'(bus.busy), 32'd1);
    end
    bus.hold = 1'b0;
    tick();
    chk("hold_c7", 32'(bus.frequencySelect), 32'd2);
    chk("hold_c7_pulse", 32'(bus.step_pulse), 32'd0);
    tick();
    chk("hold_next", 32'(bus.frequencySelect), 32'd5);
    chk("hold_next_pulse", 32'(bus.step_pulse), 32'd1);

    // stop + start together mid-entry 1: stop wins, then restart
    bus.stop = 1'b1; bus.start = 1'b1;
    tick();
    chk_idle("stop_start");
    bus.stop = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("restart_freq",  32'(bus.frequencySelect), 32'd2);
    chk("restart_idx",   32'(bus.step_idx), 32'd0);
    chk("restart_pulse", 32'(bus.step_pulse), 32'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_idle("restart_stop");

    // num_steps = 0 is ignored
    bus.num_steps = 4'd0; bus.start = 1'b1;
    tick();
    chk("ns0_busy_a", 32'(bus.busy), 32'd0);
    tick();
    chk("ns0_busy_b", 32'(bus.busy), 32'd0);
    chk("ns0_freq",   32'(bus.frequencySelect), 32'd0);
    bus.start = 1'b0;

    // num_steps = 12 clamps to 8 entries: 3+2+1+5*1 = 11 busy cycles
    for (int i = 3; i < 8; i++) wr(i, '{div: 28'(10 + i), dwell: 32'd1});
    bus.num_steps = 4'd12; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cycles = 0; last_div = 0; seen_done = 1'b0;
    for (int i = 0; i < 30 && !seen_done; i++) begin
      if (bus.busy) begin
        cycles++;
        last_div = int'(bus.frequencySelect);
      end
      if (bus.done) seen_done = 1'b1;
      else tick();
    end
    chk("clamp_done_seen", 32'(seen_done), 32'd1);
    chk("clamp_cycles",    32'(cycles), 32'd11);
    chk("clamp_last_div",  32'(last_div), 32'd17);
    tick();
    chk_idle("clamp_end");

    // Reset mid-run clears outputs but not the table
    bus.num_steps = 4'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("prereset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0; bus.start = 1'b1; bus.wr_en = 1'b1;
    bus.wr_addr = 3'd0; bus.wr_div = 28'd99; bus.wr_dwell = 32'd5;
    tick();
    chk_idle("midrun_reset");
    rst_n = 1'b1; bus.wr_en = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("post_reset_freq",  32'(bus.frequencySelect), 32'd2);
    chk("post_reset_pulse", 32'(bus.step_pulse), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
